mix_sequencer: RTL and testbench



---
 rtl/mix_sequencer_if.sv | 28 ++
 rtl/mix_sequencer.sv | 144 ++++++++++++++
 tb/tb_mix_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mix_sequencer_if.sv
// Sample/mix bus between the effect datapath, the mix sequencer and the
// output serializer. The producer side drives the sample pair and the mix
// controls. The sequencer side returns the mixed sample and its status.
interface mix_sequencer_if #(
  parameter int WIDTH  = 16,
  parameter int GAIN_W = 8
);
  logic                     sampleStrobe_i;
  logic signed [WIDTH-1:0]  pktDry_i;
  logic signed [WIDTH-1:0]  pktWet_i;
  logic        [GAIN_W:0]   mixTarget_i;
  logic                     bypass_i;
  logic signed [WIDTH-1:0]  pktMixed_o;
  logic                     pktValid_o;
  logic                     busy_o;
  logic                     overrun_o;
  logic        [GAIN_W:0]   gain_o;

  modport master (
    output sampleStrobe_i, pktDry_i, pktWet_i, mixTarget_i, bypass_i,
    input  pktMixed_o, pktValid_o, busy_o, overrun_o, gain_o
  );

  modport slave (
    input  sampleStrobe_i, pktDry_i, pktWet_i, mixTarget_i, bypass_i,
    output pktMixed_o, pktValid_o, busy_o, overrun_o, gain_o
  );
endinterface

// File: rtl/mix_sequencer.sv
// Wet/dry mix sequencer. A single shared multiplier is time-multiplexed
// over two cycles per sample to form dry*(FS-g) + wet*g. The result is then
// rounded, saturated and registered. The wet gain g ramps toward the
// programmed target by at most RAMP_STEP per completed sample.
module mix_sequencer #(
  parameter int WIDTH     = 16,
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 16
) (
  input logic clk_i,
  input logic rst_n_i,
  mix_sequencer_if.slave bus
);

  localparam int ACC_W       = WIDTH + GAIN_W + 2;
  localparam int FS_INT      = 1 << GAIN_W;
  localparam int HALF_INT    = FS_INT / 2;
  localparam int SAT_MAX_INT = (1 << (WIDTH - 1)) - 1;

  localparam logic [GAIN_W:0]         FS      = FS_INT[GAIN_W:0];
  localparam logic [GAIN_W:0]         HALF_FS = HALF_INT[GAIN_W:0];
  localparam logic [GAIN_W:0]         STEP    = RAMP_STEP[GAIN_W:0];
  localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(HALF_INT);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_INT);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-SAT_MAX_INT - 1);

  typedef enum logic [1:0] {IDLE, MUL_DRY, MUL_WET, DONE} state_t;

  state_t                   state;
  logic signed [WIDTH-1:0]  dry_q;
  logic signed [WIDTH-1:0]  wet_q;
  logic                     bypass_q;
  logic        [GAIN_W:0]   gain_cap;
  logic        [GAIN_W:0]   gain_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [WIDTH-1:0]  mixed_q;
  logic                     valid_q;
  logic                     busy_q;
  logic                     overrun_q;

  logic signed [WIDTH-1:0]  mul_a;
  logic signed [GAIN_W+1:0] mul_b;
  logic signed [ACC_W-1:0]  product;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [WIDTH-1:0]  mix_result;
  logic        [GAIN_W:0]   target;
  logic        [GAIN_W:0]   gap;
  logic        [GAIN_W:0]   gain_next;

  // Steer the one shared multiplier: dry against (FS-g) first, then wet against g.
  always_comb begin
    mul_a = wet_q;
    mul_b = signed'({1'b0, gain_cap});
    if (state == MUL_DRY) begin
      mul_a = dry_q;
      mul_b = signed'({1'b0, FS - gain_cap});
    end
  end

  assign product = ACC_W'(mul_a) * ACC_W'(mul_b);

  // Round half up, shift back to sample scale and clamp to the signed sample range.
  always_comb begin
    rounded = acc + ROUND;
    shifted = rounded >>> GAIN_W;
    if (shifted > SAT_MAX) begin
      mix_result = SAT_MAX[WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      mix_result = SAT_MIN[WIDTH-1:0];
    end else begin
      mix_result = shifted[WIDTH-1:0];
    end
  end

  // Next gain: land on the clamped target when close enough, otherwise move one step toward it.
  always_comb begin
    target    = (bus.mixTarget_i > FS) ? FS : bus.mixTarget_i;
    gain_next = target;
    gap       = '0;
    if (target > gain_q) begin
      gap = target - gain_q;
      if (gap > STEP) gain_next = gain_q + STEP;
    end else begin
      gap = gain_q - target;
      if (gap > STEP) gain_next = gain_q - STEP;
    end
  end

  // Sequencer: capture in IDLE, two multiply cycles, then publish the result and advance the gain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      dry_q     <= '0;
      wet_q     <= '0;
      bypass_q  <= 1'b0;
      gain_cap  <= HALF_FS;
      gain_q    <= HALF_FS;
      acc       <= '0;
      mixed_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= bus.sampleStrobe_i && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.sampleStrobe_i) begin
            dry_q    <= bus.pktDry_i;
            wet_q    <= bus.pktWet_i;
            bypass_q <= bus.bypass_i;
            gain_cap <= gain_q;
            busy_q   <= 1'b1;
            state    <= MUL_DRY;
          end
        end
        MUL_DRY: begin
          acc   <= product;
          state <= MUL_WET;
        end
        MUL_WET: begin
          acc   <= acc + product;
          state <= DONE;
        end
        DONE: begin
          mixed_q <= bypass_q ? dry_q : mix_result;
          valid_q <= 1'b1;
          gain_q  <= gain_next;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pktMixed_o = mixed_q;
  assign bus.pktValid_o = valid_q;
  assign bus.busy_o     = busy_q;
  assign bus.overrun_o  = overrun_q;
  assign bus.gain_o     = gain_q;

endmodule

// File: tb/tb_mix_sequencer.sv
// Self-checking bench for mix_sequencer: a transaction-level model that
// tracks per-sample results and the gain ramp, compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_mix_sequencer;

  localparam int WIDTH     = 16;
  localparam int GAIN_W    = 8;
  localparam int RAMP_STEP = 16;
  localparam int FS        = 256;

  logic clk;
  logic rst_n;

  mix_sequencer_if #(.WIDTH(WIDTH), .GAIN_W(GAIN_W)) bus ();

  mix_sequencer #(.WIDTH(WIDTH), .GAIN_W(GAIN_W), .RAMP_STEP(RAMP_STEP)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  bit check_en     = 1'b0;

  // Model state: one sample in flight at most, counted down in clock edges.
  bit m_inflight;
  int m_left;
  int m_pending;
  int m_gain;
  int exp_mixed;
  int exp_valid;
  int exp_busy;
  int exp_ovr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ramp_to(input int g, input int t);
    int tc;
    tc = (t > FS) ? FS : t;
    if (tc > g) return (tc - g <= RAMP_STEP) ? tc : g + RAMP_STEP;
    return (g - tc <= RAMP_STEP) ? tc : g - RAMP_STEP;
  endfunction

  function automatic int mix_of(input int dry, input int wet, input int g, input bit byp);
    int v;
    if (byp) return dry;
    v = dry * (FS - g) + wet * g + FS / 2;
    v = v >>> GAIN_W;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: advances one clock edge at a time from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight = 1'b0;
      m_left     = 0;
      m_pending  = 0;
      m_gain     = FS / 2;
      exp_mixed  = 0;
      exp_valid  = 0;
      exp_busy   = 0;
      exp_ovr    = 0;
    end else begin
      bit was_busy;
      was_busy  = m_inflight;
      exp_valid = 0;
      exp_ovr   = 0;
      if (m_inflight) begin
        m_left--;
        if (m_left == 0) begin
          exp_mixed  = m_pending;
          exp_valid  = 1;
          m_gain     = ramp_to(m_gain, int'(bus.mixTarget_i));
          m_inflight = 1'b0;
        end
      end
      if (bus.sampleStrobe_i) begin
        if (was_busy) begin
          exp_ovr = 1;
        end else begin
          m_pending  = mix_of(int'(bus.pktDry_i), int'(bus.pktWet_i), m_gain, bus.bypass_i);
          m_inflight = 1'b1;
          m_left     = 3;
        end
      end
      exp_busy = m_inflight ? 1 : 0;
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      checkOutput("pktMixed_o", int'(bus.pktMixed_o), exp_mixed);
      checkOutput("pktValid_o", int'(bus.pktValid_o), exp_valid);
      checkOutput("busy_o",     int'(bus.busy_o),     exp_busy);
      checkOutput("overrun_o",  int'(bus.overrun_o),  exp_ovr);
      checkOutput("gain_o",     int'(bus.gain_o),     m_gain);
    end
  end

  // Drive one strobe starting at a falling edge; don't-care data afterwards.
  task automatic applyStimulus(input int dry, input int wet, input bit byp);
    bus.pktDry_i       = 16'(dry);
    bus.pktWet_i       = 16'(wet);
    bus.bypass_i       = byp;
    bus.sampleStrobe_i = 1'b1;
    @(negedge clk);
    bus.sampleStrobe_i = 1'b0;
    bus.pktDry_i       = 16'($urandom);
    bus.pktWet_i       = 16'($urandom);
    bus.bypass_i       = 1'($urandom);
  endtask

  task automatic waitResult(output int mixed);
    int n;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (bus.pktValid_o) break;
    end
    checkOutput("latency", n, 3);
    mixed = int'(bus.pktMixed_o);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int mixed;
    int valids;
    rst_n              = 1'b1;
    bus.sampleStrobe_i = 1'b0;
    bus.pktDry_i       = '0;
    bus.pktWet_i       = '0;
    bus.bypass_i       = 1'b0;
    bus.mixTarget_i    = 9'd128;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    checkOutput("reset mixed", int'(bus.pktMixed_o), 0);
    checkOutput("reset valid", int'(bus.pktValid_o), 0);
    checkOutput("reset busy", int'(bus.busy_o), 0);
    checkOutput("reset overrun", int'(bus.overrun_o), 0);
    checkOutput("reset gain", int'(bus.gain_o), 128);
    check_en = 1'b1;

    // Basic 50% mix
    applyStimulus(1000, 3000, 1'b0);
    waitResult(mixed);
    checkOutput("half mix", mixed, 2000);
    checkOutput("half gain", int'(bus.gain_o), 128);

    // Negative rounding
    applyStimulus(-3, 0, 1'b0);
    waitResult(mixed);
    checkOutput("round neg", mixed, -1);

    // Ramp down to g=0, then full-scale dry must not overflow
    bus.mixTarget_i = 9'd0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(int'($urandom_range(0, 2000)), 5, 1'b0);
      waitResult(mixed);
      checkOutput("ramp down gain", int'(bus.gain_o), 128 - 16 * k);
    end
    applyStimulus(32767, 32767, 1'b0);
    waitResult(mixed);
    checkOutput("full scale", mixed, 32767);

    // Reset while the sample is in MUL_WET
    bus.mixTarget_i = 9'd0;
    applyStimulus(4000, 4000, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort mixed", int'(bus.pktMixed_o), 0);
    checkOutput("abort valid", int'(bus.pktValid_o), 0);
    checkOutput("abort busy", int'(bus.busy_o), 0);
    checkOutput("abort gain", int'(bus.gain_o), 128);
    @(negedge clk);
    #2 rst_n = 1'b1;
    valids = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.pktValid_o) valids++;
    end
    checkOutput("abort no valid", valids, 0);

    // Ramp up from 128 to 256
    bus.mixTarget_i = 9'd256;
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(0, 1000, 1'b0);
      waitResult(mixed);
      checkOutput("ramp up gain", int'(bus.gain_o), (128 + 16 * k > 256) ? 256 : 128 + 16 * k);
    end
    checkOutput("ramp full wet", mixed, 1000);
    bus.mixTarget_i = 9'd300;
    applyStimulus(0, 1000, 1'b0);
    waitResult(mixed);
    checkOutput("clamp gain", int'(bus.gain_o), 256);
    checkOutput("clamp wet", mixed, 1000);

    // Overrun: second strobe two cycles after the first is dropped
    applyStimulus(300, 300, 1'b0);
    @(negedge clk);
    bus.pktDry_i       = -16'sd7777;
    bus.pktWet_i       = -16'sd7777;
    bus.sampleStrobe_i = 1'b1;
    @(negedge clk);
    bus.sampleStrobe_i = 1'b0;
    checkOutput("overrun pulse", int'(bus.overrun_o), 1);
    checkOutput("overrun early valid", int'(bus.pktValid_o), 0);
    @(negedge clk);
    checkOutput("overrun valid", int'(bus.pktValid_o), 1);
    checkOutput("overrun data", int'(bus.pktMixed_o), 300);
    checkOutput("overrun cleared", int'(bus.overrun_o), 0);
    applyStimulus(-500, -500, 1'b0);
    waitResult(mixed);
    checkOutput("after overrun", mixed, -500);

    // Bypass at g=64: dry passes unmodified while gain keeps ramping
    bus.mixTarget_i = 9'd64;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(10, 20, 1'b0);
      waitResult(mixed);
    end
    checkOutput("bypass setup gain", int'(bus.gain_o), 64);
    bus.mixTarget_i = 9'd0;
    applyStimulus(-1234, 5000, 1'b1);
    waitResult(mixed);
    checkOutput("bypass data", mixed, -1234);
    checkOutput("bypass ramp", int'(bus.gain_o), 48);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) bus.mixTarget_i = 9'($urandom_range(0, 511));
      bus.sampleStrobe_i = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: bus.pktDry_i = 16'sd32767;
        1: bus.pktDry_i = -16'sd32768;
        default: bus.pktDry_i = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: bus.pktWet_i = 16'sd32767;
        1: bus.pktWet_i = -16'sd32768;
        default: bus.pktWet_i = 16'($urandom);
      endcase
      bus.bypass_i = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    bus.sampleStrobe_i = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
